// File: rtl/risc_v_pipeline_pkg.sv
// Shared types for the RISC-V pipeline hazard controller: FSM state and forwarding selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package risc_v_pipeline_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  // EX operand source selects
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one EX source operand; EX/MEM result beats MEM/WB result.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs every cycle.
// Ports: ex_rs_i (EX source reg), mem_rd_i/mem_regwen_i, wb_rd_i/wb_regwen_i, fwd_o (select).
module hazard_fwd_unit
  import risc_v_pipeline_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] ex_rs_i,
  input  logic [RA_W-1:0] mem_rd_i,
  input  logic            mem_regwen_i,
  input  logic [RA_W-1:0] wb_rd_i,
  input  logic            wb_regwen_i,
  output logic [1:0]      fwd_o
);

  always_comb begin
    fwd_o = FWD_REG;
    // x0 is never a real producer, so rd==0 never forwards
    if (mem_regwen_i && (mem_rd_i != '0) && (mem_rd_i == ex_rs_i)) begin
      fwd_o = FWD_EXMEM;
    end else if (wb_regwen_i && (wb_rd_i != '0) && (wb_rd_i == ex_rs_i)) begin
      fwd_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, EX redirect flushes, data-memory wait stalls, forwarding, perf counters.
// Latency: enables/flushes/forward selects are combinational in the current cycle; counters update on the edge.
// Backpressure: a pending data-memory access (mem_req & ~mem_ready) freezes PC..EX/MEM and bubbles MEM/WB.
// Ports: clk/rst; ID/EX/MEM/WB register ids and write enables; redirect_i; mem_req_i/mem_ready_i;
//        stage enables and flushes; fwd_a_o/fwd_b_o; stall_cnt_o/flush_cnt_o.
module pipeline_hazard_ctrl
  import risc_v_pipeline_pkg::*;
#(
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs1_i,
  input  logic [RA_W-1:0]  id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [RA_W-1:0]  ex_rs1_i,
  input  logic [RA_W-1:0]  ex_rs2_i,
  input  logic [RA_W-1:0]  ex_rd_i,
  input  logic             ex_regwen_i,
  input  logic             ex_is_load_i,
  input  logic [RA_W-1:0]  mem_rd_i,
  input  logic             mem_regwen_i,
  input  logic [RA_W-1:0]  wb_rd_i,
  input  logic             wb_regwen_i,
  input  logic             redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Enough bits to hold FLUSH_CYCLES-1
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(FLUSH_CYCLES - 1);

  hz_state_t        state_q, state_d;
  hz_state_t        ret_q, ret_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [1:0]       fwd_a_raw, fwd_b_raw;
  logic             lu, mw;

  hazard_fwd_unit #(.RA_W(RA_W)) u_fwd_a (
    .ex_rs_i      (ex_rs1_i),
    .mem_rd_i     (mem_rd_i),
    .mem_regwen_i (mem_regwen_i),
    .wb_rd_i      (wb_rd_i),
    .wb_regwen_i  (wb_regwen_i),
    .fwd_o        (fwd_a_raw)
  );

  hazard_fwd_unit #(.RA_W(RA_W)) u_fwd_b (
    .ex_rs_i      (ex_rs2_i),
    .mem_rd_i     (mem_rd_i),
    .mem_regwen_i (mem_regwen_i),
    .wb_rd_i      (wb_rd_i),
    .wb_regwen_i  (wb_regwen_i),
    .fwd_o        (fwd_b_raw)
  );

  assign lu = ex_is_load_i && ex_regwen_i && (ex_rd_i != '0) &&
              ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
               (id_use_rs2_i && (id_rs2_i == ex_rd_i)));
  assign mw = mem_req_i && !mem_ready_i;

  always_comb begin
    state_d        = state_q;
    ret_d          = ret_q;
    cnt_d          = cnt_q;
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_en_o     = 1'b1;
    id_ex_flush_o  = 1'b0;
    ex_mem_en_o    = 1'b1;
    mem_wb_flush_o = 1'b0;

    if (mw) begin
      // Memory wait dominates everything; redirect is held off and the
      // redirect countdown stays frozen until the access completes.
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      mem_wb_flush_o = 1'b1;
      state_d        = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        ret_d = state_q;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (redirect_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = REDIRECT;
              cnt_d   = CNT_RELOAD;
            end
          end else if (lu) begin
            // One bubble into EX; the load moves on, so lu clears next cycle.
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
          end
        end
        REDIRECT: begin
          if_id_flush_o = 1'b1;
          if (redirect_i) begin
            id_ex_flush_o = 1'b1;
            cnt_d         = CNT_RELOAD;
          end else if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        MEM_WAIT: begin
          // Access completed this cycle: pipeline advances, resume saved state next cycle.
          state_d = ret_q;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    // While reset is held, every stage is frozen and flushed.
    if (rst) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      if_id_flush_o  = 1'b1;
      id_ex_en_o     = 1'b0;
      id_ex_flush_o  = 1'b1;
      ex_mem_en_o    = 1'b0;
      mem_wb_flush_o = 1'b1;
    end
  end

  assign fwd_a_o = rst ? FWD_REG : fwd_a_raw;
  assign fwd_b_o = rst ? FWD_REG : fwd_b_raw;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (if_id_flush_o && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboarded bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random traffic.
// Latency: expectations are for the same cycle the stimulus is applied.
// Backpressure: n/a.
module tb_pipeline_hazard_ctrl;

  localparam int FC = 2;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rs1_i, ex_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i;
  logic       id_use_rs1_i, id_use_rs2_i, ex_regwen_i, ex_is_load_i;
  logic       mem_regwen_i, wb_regwen_i, redirect_i, mem_req_i, mem_ready_i;
  logic       pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o;
  logic       ex_mem_en_o, mem_wb_flush_o;
  logic [1:0] fwd_a_o, fwd_b_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  pipeline_hazard_ctrl #(.RA_W(5), .FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_rs1_i(ex_rs1_i), .ex_rs2_i(ex_rs2_i), .ex_rd_i(ex_rd_i),
    .ex_regwen_i(ex_regwen_i), .ex_is_load_i(ex_is_load_i),
    .mem_rd_i(mem_rd_i), .mem_regwen_i(mem_regwen_i),
    .wb_rd_i(wb_rd_i), .wb_regwen_i(wb_regwen_i),
    .redirect_i(redirect_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .if_id_flush_o(if_id_flush_o),
    .id_ex_en_o(id_ex_en_o), .id_ex_flush_o(id_ex_flush_o),
    .ex_mem_en_o(ex_mem_en_o), .mem_wb_flush_o(mem_wb_flush_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  typedef struct {
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic use1, use2, ex_wen, ex_load, mem_wen, wb_wen, redir, req, rdy;
  } in_t;

  // ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
  typedef struct packed {
    logic [6:0]  ctrl;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    logic [31:0] fcnt;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: "waiting" = a data access is outstanding, "flush_left" =
  // remaining IF/ID flush cycles still owed to the last redirect.
  bit          m_waiting;
  int          m_flush_left;
  longint      m_stalls, m_flushes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] fwd_ref(logic [4:0] rs, logic [4:0] mrd, logic mwen,
                                         logic [4:0] wrd, logic wwen);
    if (mwen && mrd != 5'd0 && mrd == rs) return 2'b01;
    if (wwen && wrd != 5'd0 && wrd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic in_t idle_in();
    in_t v;
    v.rst = 1'b0;
    v.id_rs1 = '0; v.id_rs2 = '0; v.ex_rs1 = '0; v.ex_rs2 = '0;
    v.ex_rd = '0; v.mem_rd = '0; v.wb_rd = '0;
    v.use1 = 0; v.use2 = 0; v.ex_wen = 0; v.ex_load = 0; v.mem_wen = 0; v.wb_wen = 0;
    v.redir = 0; v.req = 0; v.rdy = 0;
    return v;
  endfunction

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 3));
  endfunction

  task automatic apply(input in_t v);
    out_t e;
    bit pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, mwb_fl;
    bit lu, mw;
    @(negedge clk);
    rst = v.rst;
    id_rs1_i = v.id_rs1; id_rs2_i = v.id_rs2; ex_rs1_i = v.ex_rs1; ex_rs2_i = v.ex_rs2;
    ex_rd_i = v.ex_rd; mem_rd_i = v.mem_rd; wb_rd_i = v.wb_rd;
    id_use_rs1_i = v.use1; id_use_rs2_i = v.use2; ex_regwen_i = v.ex_wen;
    ex_is_load_i = v.ex_load; mem_regwen_i = v.mem_wen; wb_regwen_i = v.wb_wen;
    redirect_i = v.redir; mem_req_i = v.req; mem_ready_i = v.rdy;

    if (v.rst) begin
      m_waiting = 0; m_flush_left = 0; m_stalls = 0; m_flushes = 0;
      e.ctrl = 7'b0010101; e.fa = 2'b00; e.fb = 2'b00; e.sc = '0; e.fcnt = '0;
      exp_q.push_back(e);
      return;
    end

    e.sc   = 32'(m_stalls);
    e.fcnt = 32'(m_flushes);
    e.fa   = fwd_ref(v.ex_rs1, v.mem_rd, v.mem_wen, v.wb_rd, v.wb_wen);
    e.fb   = fwd_ref(v.ex_rs2, v.mem_rd, v.mem_wen, v.wb_rd, v.wb_wen);

    mw = v.req && !v.rdy;
    lu = v.ex_load && v.ex_wen && v.ex_rd != 0 &&
         ((v.use1 && v.id_rs1 == v.ex_rd) || (v.use2 && v.id_rs2 == v.ex_rd));
    pc_en = 1; ifid_en = 1; idex_en = 1; exmem_en = 1;
    ifid_fl = 0; idex_fl = 0; mwb_fl = 0;

    if (mw) begin
      pc_en = 0; ifid_en = 0; idex_en = 0; exmem_en = 0; mwb_fl = 1;
      m_waiting = 1;
    end else if (m_waiting) begin
      m_waiting = 0;
    end else if (v.redir) begin
      ifid_fl = 1; idex_fl = 1;
      m_flush_left = FC - 1;
    end else if (m_flush_left > 0) begin
      ifid_fl = 1;
      m_flush_left--;
    end else if (lu) begin
      pc_en = 0; ifid_en = 0; idex_fl = 1;
    end

    if (!pc_en && m_stalls < 64'hFFFF_FFFF) m_stalls++;
    if (ifid_fl && m_flushes < 64'hFFFF_FFFF) m_flushes++;
    e.ctrl = {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, mwb_fl};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: the DUT presents a full set of outputs every cycle.
  initial begin
    out_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl", 32'({pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
                         ex_mem_en_o, mem_wb_flush_o}), 32'(e.ctrl));
        chk("fwd_a", 32'(fwd_a_o), 32'(e.fa));
        chk("fwd_b", 32'(fwd_b_o), 32'(e.fb));
        chk("stall_cnt", stall_cnt_o, e.sc);
        chk("flush_cnt", flush_cnt_o, e.fcnt);
        cyc++;
      end
    end
  end

  initial begin
    in_t v;
    rst = 1'b1;
    id_rs1_i = '0; id_rs2_i = '0; ex_rs1_i = '0; ex_rs2_i = '0; ex_rd_i = '0;
    mem_rd_i = '0; wb_rd_i = '0; id_use_rs1_i = 0; id_use_rs2_i = 0; ex_regwen_i = 0;
    ex_is_load_i = 0; mem_regwen_i = 0; wb_regwen_i = 0; redirect_i = 0;
    mem_req_i = 0; mem_ready_i = 0;

    // Reset state
    v = idle_in(); v.rst = 1; apply(v); apply(v);
    v = idle_in(); apply(v);

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID, then the bubble
    v = idle_in(); v.ex_load = 1; v.ex_wen = 1; v.ex_rd = 5;
    v.id_rs1 = 5; v.id_rs2 = 1; v.use1 = 1; v.use2 = 1; apply(v);
    v = idle_in(); v.id_rs1 = 5; v.id_rs2 = 1; v.use1 = 1; v.use2 = 1; apply(v);

    // Single redirect: two flush cycles
    v = idle_in(); v.redir = 1; apply(v);
    v = idle_in(); apply(v); apply(v);

    // Memory wait during the second redirect flush cycle
    v = idle_in(); v.redir = 1; apply(v);
    v = idle_in(); v.req = 1; v.rdy = 0; apply(v); apply(v); apply(v);
    v.rdy = 1; apply(v);
    v = idle_in(); apply(v); apply(v);

    // Forwarding priority and x0 suppression
    v = idle_in(); v.mem_rd = 7; v.wb_rd = 7; v.ex_rs1 = 7; v.ex_rs2 = 7;
    v.mem_wen = 1; v.wb_wen = 1; apply(v);
    v.mem_wen = 0; apply(v);
    v.mem_rd = 0; v.wb_rd = 0; v.ex_rs1 = 0; v.ex_rs2 = 0; v.mem_wen = 1; apply(v);

    // Redirect and load-use together: redirect wins, no stall
    v = idle_in(); v.redir = 1; v.ex_load = 1; v.ex_wen = 1; v.ex_rd = 3;
    v.id_rs2 = 3; v.use2 = 1; apply(v);
    v = idle_in(); apply(v); apply(v);

    // Reset pulsed while redirect flush is in progress
    v = idle_in(); v.redir = 1; apply(v);
    v = idle_in(); v.rst = 1; apply(v);
    v = idle_in(); apply(v); apply(v);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      v = idle_in();
      v.rst     = ($urandom_range(0, 99) == 0);
      v.id_rs1  = rnd_reg(); v.id_rs2 = rnd_reg();
      v.ex_rs1  = rnd_reg(); v.ex_rs2 = rnd_reg(); v.ex_rd = rnd_reg();
      v.mem_rd  = rnd_reg(); v.wb_rd = rnd_reg();
      v.use1    = 1'($urandom_range(0, 1)); v.use2 = 1'($urandom_range(0, 1));
      v.ex_wen  = 1'($urandom_range(0, 1)); v.ex_load = 1'($urandom_range(0, 1));
      v.mem_wen = 1'($urandom_range(0, 1)); v.wb_wen = 1'($urandom_range(0, 1));
      v.redir   = ($urandom_range(0, 6) == 0);
      v.req     = ($urandom_range(0, 3) == 0);
      v.rdy     = 1'($urandom_range(0, 1));
      apply(v);
    end

    @(negedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
